// File: rtl/pio_osr_pipe_pkg.sv
// Shared types and helpers for the PIO output shift register.
// Holds the shift direction enum, the decoded-op struct and the saturating counter add.
package pio_osr_pkg;

    localparam int MAX_SH_W = 6;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } osr_dir_e;

    typedef struct packed {
        logic                out;
        logic                pull;
        logic                block;
        logic                mov;
        logic [MAX_SH_W-1:0] bits;
    } osr_op_t;

    // Counter advance clamped at the register width; 9-bit sum so no overflow for widths up to 64
    function automatic logic [7:0] sat_add(input logic [7:0] count,
                                           input logic [7:0] n,
                                           input logic [7:0] data_w);
        logic [8:0] sum;
        sum = {1'b0, count} + {1'b0, n};
        if (sum > {1'b0, data_w}) begin
            sat_add = data_w;
        end else begin
            sat_add = sum[7:0];
        end
    endfunction

endpackage

// File: rtl/pio_osr_pipe_if.sv
// TX FIFO pop interface between the FIFO head (master) and the OSR (slave).
interface pio_osr_pipe_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_valid;
    logic              fifo_ready;

    modport master (output fifo_data, output fifo_valid, input fifo_ready);
    modport slave  (input fifo_data, input fifo_valid, output fifo_ready);
endinterface

// File: rtl/pio_osr_pipe_shifter.sv
// Combinational barrel shifter for the OSR: produces the right-aligned OUT
// field and the zero-filled remainder for a shift of n (1..DATA_W) bits.
module pio_osr_shifter
    import pio_osr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic [DATA_W-1:0] shift_reg,
    input  osr_dir_e          dir,
    input  logic [CNT_W-1:0]  n,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] shift_next
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

    logic [DATA_W:0]   mask_wide_s;
    logic [CNT_W-1:0]  rem_s;

    // Shifting by DATA_W yields zero, so n == DATA_W needs no special case
    always_comb begin
        mask_wide_s = ({{DATA_W{1'b0}}, 1'b1} << n) - {{DATA_W{1'b0}}, 1'b1};
        rem_s       = FULL - n;
        case (dir)
            SHIFT_LEFT: begin
                out_data   = shift_reg >> rem_s;
                shift_next = shift_reg << n;
            end
            SHIFT_RIGHT: begin
                out_data   = shift_reg & mask_wide_s[DATA_W-1:0];
                shift_next = shift_reg >> n;
            end
            default: begin
                out_data   = {DATA_W{1'b0}};
                shift_next = shift_reg;
            end
        endcase
    end

endmodule

// File: rtl/pio_osr_pipe.sv
// PIO output shift register for one state machine: PULL/MOV/OUT with autopull.
// Optional one-entry TX prefetch register is compiled in with PIO_OSR_PREFETCH_EN.
module pio_osr_pipe
    import pio_osr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W),
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              penable,
    input  logic              restart,
    input  logic              stalled,
    input  logic              cfg_dir,
    input  logic              cfg_autopull,
    input  logic [SH_W-1:0]   cfg_thresh,
    input  logic              op_out,
    input  logic [SH_W-1:0]   op_bits,
    input  logic              op_pull,
    input  logic              op_block,
    input  logic              op_mov,
    input  logic [DATA_W-1:0] mov_data,
    input  logic [DATA_W-1:0] x_data,
    pio_osr_pipe_if.slave     fifo,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              stall_req,
    output logic [CNT_W-1:0]  shift_count,
    output logic              empty_la
);
    localparam logic [CNT_W-1:0]  FULL   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_Z  = {CNT_W{1'b0}};
    localparam logic [SH_W-1:0]   SH_Z   = {SH_W{1'b0}};
    localparam logic [MAX_SH_W-1:0] BITS_Z = {MAX_SH_W{1'b0}};

    logic [DATA_W-1:0] shift_r;
    logic [CNT_W-1:0]  count_r;

    osr_op_t           op_s;
    logic [CNT_W-1:0]  n_s, thresh_s, base_s, la_count_s;
    logic              run_s, op_act_s, do_mov_s, do_pull_s, do_out_s, idle_s, need_pull_s;
    logic              avail_s, consume_s, stall_s, valid_s;
    logic [DATA_W-1:0] avail_data_s, src_s, sh_out_s, sh_next_s, shift_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;

    // Decode the op by priority and resolve zero-encoded bit counts
    always_comb begin
        op_s        = '{out: op_out, pull: op_pull, block: op_block, mov: op_mov,
                        bits: MAX_SH_W'(op_bits)};
        n_s         = (op_s.bits == BITS_Z) ? FULL : CNT_W'(op_s.bits);
        thresh_s    = (cfg_thresh == SH_Z) ? FULL : CNT_W'(cfg_thresh);
        run_s       = reset_n && !restart && penable;
        op_act_s    = run_s && !stalled;
        do_mov_s    = op_act_s && op_s.mov;
        do_pull_s   = op_act_s && !op_s.mov && op_s.pull;
        do_out_s    = op_act_s && !op_s.mov && !op_s.pull && op_s.out;
        idle_s      = run_s && !(op_act_s && (op_s.mov || op_s.pull || op_s.out));
        need_pull_s = cfg_autopull && (count_r >= thresh_s);
    end

`ifdef PIO_OSR_PREFETCH_EN
    logic              pf_valid_r;
    logic [DATA_W-1:0] pf_data_r;
    logic              fill_s;

    // Loads are served from the prefetch entry
    always_comb begin
        avail_s      = pf_valid_r;
        avail_data_s = pf_data_r;
    end

    // Entry refills whenever it is (or is becoming) empty, regardless of penable/stalled
    always_comb begin
        fill_s          = reset_n && !restart && fifo.fifo_valid && (!pf_valid_r || consume_s);
        fifo.fifo_ready = fill_s;
    end

    // Prefetch entry; restart drops whatever it holds
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pf_valid_r <= 1'b0;
            pf_data_r  <= {DATA_W{1'b0}};
        end else if (restart) begin
            pf_valid_r <= 1'b0;
        end else if (fill_s) begin
            pf_valid_r <= 1'b1;
            pf_data_r  <= fifo.fifo_data;
        end else if (consume_s) begin
            pf_valid_r <= 1'b0;
        end else begin
            pf_valid_r <= pf_valid_r;
        end
    end
`else
    // Loads take the FIFO head directly and pop it in the same cycle
    always_comb begin
        avail_s         = fifo.fifo_valid;
        avail_data_s    = fifo.fifo_data;
        fifo.fifo_ready = consume_s;
    end
`endif

    // An autopulling OUT shifts the freshly loaded word, not the stale register
    always_comb begin
        if (do_out_s && need_pull_s) begin
            src_s = avail_data_s;
        end else begin
            src_s = shift_r;
        end
    end

    pio_osr_shifter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shifter (
        .shift_reg  (src_s),
        .dir        (osr_dir_e'(cfg_dir)),
        .n          (n_s),
        .out_data   (sh_out_s),
        .shift_next (sh_next_s)
    );

    // Next OSR contents, counter, pop and stall decision
    always_comb begin
        shift_nxt_s = shift_r;
        count_nxt_s = count_r;
        base_s      = count_r;
        consume_s   = 1'b0;
        stall_s     = 1'b0;
        valid_s     = 1'b0;
        if (do_mov_s) begin
            shift_nxt_s = mov_data;
            count_nxt_s = CNT_Z;
        end else if (do_pull_s) begin
            if (avail_s) begin
                shift_nxt_s = avail_data_s;
                count_nxt_s = CNT_Z;
                consume_s   = 1'b1;
            end else if (op_s.block) begin
                stall_s = 1'b1;
            end else begin
                shift_nxt_s = x_data;
                count_nxt_s = CNT_Z;
            end
        end else if (do_out_s) begin
            if (need_pull_s && !avail_s) begin
                stall_s = 1'b1;
            end else begin
                if (need_pull_s) begin
                    consume_s = 1'b1;
                    base_s    = CNT_Z;
                end else begin
                    base_s = count_r;
                end
                shift_nxt_s = sh_next_s;
                count_nxt_s = CNT_W'(sat_add(8'(base_s), 8'(n_s), 8'(DATA_W)));
                valid_s     = 1'b1;
            end
        end else if (idle_s && need_pull_s && avail_s) begin
            shift_nxt_s = avail_data_s;
            count_nxt_s = CNT_Z;
            consume_s   = 1'b1;
        end else begin
            shift_nxt_s = shift_r;
        end
    end

    // OSR state; restart only rewinds the counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_r <= {DATA_W{1'b0}};
            count_r <= FULL;
        end else if (restart) begin
            count_r <= FULL;
        end else begin
            shift_r <= shift_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Outputs are forced quiet while reset is asserted
    always_comb begin
        if (do_out_s && valid_s) begin
            la_count_s = count_nxt_s;
        end else begin
            la_count_s = count_r;
        end
        out_data    = valid_s ? sh_out_s : {DATA_W{1'b0}};
        out_valid   = valid_s;
        stall_req   = stall_s;
        shift_count = reset_n ? count_r : FULL;
        empty_la    = reset_n && (la_count_s >= thresh_s);
    end

endmodule
